mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: memory wait cycles before a bus-error abort (range 1..255).
REQ-002 SHALL have ports clk in 1 (single clock) and rst_n in 1; reset is asynchronous and active-low.
REQ-003 SHALL have ports ex_valid in 1, ex_opcode in 5, ex_func3 in 3, ex_rd in 5: issuing instruction from the EX stage.
REQ-004 SHALL have ports ex_alu_out in 32 (EX result or effective address) and ex_store_data in 32 (rs2 value).
REQ-005 SHALL have port ex_ready out 1: the stage accepts EX input this cycle.
REQ-006 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_be out 4, mem_wdata out 32, mem_rdata in 32, mem_ack in 1.
REQ-007 SHALL have ports wb_valid out 1, wb_rd out 5, wb_data out 32, bus_err out 1.

Function
REQ-008 SHALL accept an instruction when ex_valid and ex_ready are both high; ex_ready = (state == IDLE).
REQ-009 SHALL, for opcodes other than 00000 (load) and 01000 (store), register ex_alu_out into wb_data with wb_valid high the next cycle (1-cycle latency, no memory access).
REQ-010 SHALL hold branch opcode 11000 and store results off the writeback path: wb_valid low for those.
REQ-011 SHALL implement FSM IDLE -> ACCESS on an accepted load/store; ACCESS -> IDLE on mem_ack or on timeout.
REQ-012 SHALL, in ACCESS, hold mem_req high and mem_addr/mem_we/mem_be/mem_wdata stable until the mem_ack cycle.
REQ-013 SHALL drive mem_addr = {ex_alu_out[31:2], 2'b00}.
REQ-014 SHALL set byte enables from func3[1:0] and addr[1:0]: byte -> 1 << addr[1:0]; half -> 2'b11 << {addr[1],1'b0}; word -> 4'b1111.
REQ-015 SHALL place store data in lanes: sb replicates byte 4x, sh replicates half 2x, sw passes through.
REQ-016 SHALL, on load ack, extract the lane selected by addr[1:0] and sign-extend (func3 000, 001) or zero-extend (100, 101); func3 010 passes the word.
REQ-017 SHALL assert wb_valid for exactly one cycle, the cycle after mem_ack, for loads; stores complete silently.
REQ-018 SHALL count wait cycles in ACCESS; at TIMEOUT_CYC without ack, drop mem_req, pulse bus_err for 1 cycle, return to IDLE, no writeback.
REQ-019 SHALL ignore mem_ack outside ACCESS.
REQ-020 SHALL give ack precedence when mem_ack arrives in the same cycle the counter reaches TIMEOUT_CYC.
REQ-021 SHALL treat rd = 0 as a valid writeback target with wb_data forced to 0.

Reset
REQ-022 SHALL, on rst_n low, force IDLE, counter 0, and drive mem_req, mem_we, wb_valid, bus_err to 0; mem_addr, mem_be, mem_wdata, wb_rd, wb_data to 0.
REQ-023 SHALL abort an in-flight access immediately on reset; a later mem_ack SHALL be ignored.

Configuration
REQ-024 SHALL support macro MISALIGN_TRAP_EN: when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 issues no mem_req, pulses bus_err the next cycle, and produces no writeback.
REQ-025 SHALL, without MISALIGN_TRAP_EN, force-align misaligned accesses by ignoring the offending low address bits.

Structure
REQ-026 SHALL take opcode constants (LOAD 00000, STORE 01000, BRANCH 11000), func3 width codes, and the FSM state enum from the shared CPU package.
REQ-027 SHALL put lane extraction and sign extension in sub-module load_align (combinational).

Verification
REQ-028 lw: ex_alu_out=0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after req -> wb_data=0xDEADBEEF, wb_valid 1 cycle after ack.
REQ-029 lb: addr 0x103, rdata 0x80FF0000 -> wb_data 0xFFFFFF80; the same access as lbu -> 0x00000080.
REQ-030 sh: addr 0x202, data 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, no wb_valid.
REQ-031 Load with no ack for 64 cycles -> mem_req falls, bus_err 1-cycle pulse, ex_ready high next cycle.
REQ-032 rst_n low during ACCESS, then ack after reset -> state IDLE, no wb_valid, all outputs 0.
REQ-033 With MISALIGN_TRAP_EN, lw at 0x101 -> no mem_req, bus_err pulse; without it -> mem_addr 0x100, mem_be 1111.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared CPU definitions: opcodes, access-width codes, memory-stage FSM states, lane helpers.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package mem_access_stage_pkg;

   // Major opcodes seen by the memory stage
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;

   // Access width, taken from func3[1:0]; func3[2] selects zero-extension on loads
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // Byte enables for an access of width sz at byte offset off within the word.
   // Halves only look at off[1] and words ignore off, which force-aligns sloppy addresses.
   function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return 4'b0011 << {off[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate store data into every lane so the enabled lanes always carry it
   function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         SZ_BYTE: return {4{d[7:0]}};
         SZ_HALF: return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // True when the offset is not a multiple of the access width
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane extraction: picks the addressed byte/half from the read word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none, pure datapath.
module load_align
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  func3,
   output logic [31:0] data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Select the lane, then extend according to func3[2] (1 = unsigned)
   always_comb begin
      sel_byte = rdata[{off, 3'b000} +: 8];
      sel_half = off[1] ? rdata[31:16] : rdata[15:0];
      case (func3[1:0])
         SZ_BYTE: data = func3[2] ? {24'h000000, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
         SZ_HALF: data = func3[2] ? {16'h0000, sel_half}   : {{16{sel_half[15]}}, sel_half};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage: passes ALU results to writeback, runs loads/stores on a req/ack bus with timeout.
// Latency: non-memory ops 1 cycle; loads 1 cycle after mem_ack; bus_err 1 cycle after timeout/trap.
// Backpressure: ex_ready is low while an access is outstanding. Optional macro: MISALIGN_TRAP_EN.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [4:0]  ex_opcode,
   input  logic [2:0]  ex_func3,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_store_data,
   output logic        ex_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        bus_err
);

   // Counter value on the last wait cycle before the access is abandoned
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        lsu_load;
   logic [4:0]  lsu_rd;
   logic [2:0]  lsu_func3;
   logic [1:0]  lsu_off;
   logic [31:0] load_data;
   logic        is_mem;
   logic        is_store;
   logic        trap;

   assign ex_ready = (state == IDLE);
   assign is_store = (ex_opcode == OP_STORE);
   assign is_mem   = (ex_opcode == OP_LOAD) || is_store;

`ifdef MISALIGN_TRAP_EN
   assign trap = misaligned(ex_func3[1:0], ex_alu_out[1:0]);
`else
   assign trap = 1'b0;
`endif

   load_align u_load_align (
      .rdata (mem_rdata),
      .off   (lsu_off),
      .func3 (lsu_func3),
      .data  (load_data)
   );

   // Stage FSM: issue, wait for ack or timeout, and drive all bus/writeback outputs as registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         bus_err   <= 1'b0;
         lsu_load  <= 1'b0;
         lsu_rd    <= '0;
         lsu_func3 <= '0;
         lsu_off   <= '0;
      end else begin
         wb_valid <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_valid) begin
                  if (is_mem) begin
                     if (trap) begin
                        bus_err <= 1'b1;
                     end else begin
                        state     <= ACCESS;
                        wait_cnt  <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {ex_alu_out[31:2], 2'b00};
                        mem_be    <= lane_enables(ex_func3[1:0], ex_alu_out[1:0]);
                        mem_wdata <= store_lanes(ex_func3[1:0], ex_store_data);
                        lsu_load  <= ~is_store;
                        lsu_rd    <= ex_rd;
                        lsu_func3 <= ex_func3;
                        lsu_off   <= ex_alu_out[1:0];
                     end
                  end else if (ex_opcode != OP_BRANCH) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= ex_rd;
                     wb_data  <= (ex_rd == 5'd0) ? 32'h0 : ex_alu_out;
                  end
               end
            end
            ACCESS: begin
               // Ack is checked first so it wins over a timeout in the same cycle
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (lsu_load) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= lsu_rd;
                     wb_data  <= (lsu_rd == 5'd0) ? 32'h0 : load_data;
                  end
               end else if (wait_cnt == LAST_WAIT) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed cases plus randomized ops against a transaction model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_stage;

   localparam int TO = 64;
   localparam logic [4:0] LD = 5'b00000;
   localparam logic [4:0] ST = 5'b01000;
   localparam logic [4:0] BR = 5'b11000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [4:0]  ex_opcode;
   logic [2:0]  ex_func3;
   logic [4:0]  ex_rd;
   logic [31:0] ex_alu_out;
   logic [31:0] ex_store_data;
   logic        ex_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_opcode     (ex_opcode),
      .ex_func3      (ex_func3),
      .ex_rd         (ex_rd),
      .ex_alu_out    (ex_alu_out),
      .ex_store_data (ex_store_data),
      .ex_ready      (ex_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_be        (mem_be),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .bus_err       (bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---- reference model: access arithmetic in plain byte terms ----
   function automatic int unsigned nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit misal(input logic [2:0] f3, input logic [31:0] a);
      return (a % nbytes(f3)) != 0;
   endfunction

   // first byte lane touched: word offset rounded down to the access width
   function automatic int unsigned lane0(input logic [2:0] f3, input logic [31:0] a);
      int unsigned o;
      o = a % 4;
      return o - (o % nbytes(f3));
   endfunction

   function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
      int unsigned v;
      v = ((1 << nbytes(f3)) - 1) << lane0(f3, a);
      return v & 32'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (nbytes(f3))
         1:       return (d & 32'hFF) * 32'h01010101;
         2:       return (d & 32'hFFFF) * 32'h00010001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd_word);
      logic [31:0] v;
      logic [31:0] mask;
      int unsigned n;
      n = nbytes(f3);
      if (n == 4) return rd_word;
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = (rd_word >> (8 * lane0(f3, a))) & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   // Issue one instruction and follow it to completion, checking against the model
   task automatic run_op(input logic [4:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd, input int dly,
                         input logic [31:0] rdata, input bit ack);
      bit is_mem;
      bit is_ld;
      bit trap;
      int n;
      logic [31:0] a_exp;
      is_mem = (op == LD) || (op == ST);
      is_ld  = (op == LD);
      trap   = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap = is_mem && misal(f3, alu);
`endif
      a_exp = alu & 32'hFFFF_FFFC;
      chk("ex_ready_idle", {31'b0, ex_ready}, 32'd1);
      ex_valid = 1'b1; ex_opcode = op; ex_func3 = f3; ex_rd = rd;
      ex_alu_out = alu; ex_store_data = sd;
      mem_ack = 1'($urandom_range(0, 1));   // stray ack while idle must be ignored
      mem_rdata = $urandom;
      @(negedge clk);
      ex_valid = 1'b0; mem_ack = 1'b0;
      if (!is_mem) begin
         chk("alu_wb_valid", {31'b0, wb_valid}, {31'b0, op != BR});
         if (op != BR) begin
            chk("alu_wb_rd", {27'b0, wb_rd}, {27'b0, rd});
            chk("alu_wb_data", wb_data, (rd == 0) ? 32'h0 : alu);
         end
         chk("alu_no_req", {31'b0, mem_req}, 32'd0);
         @(negedge clk);
         chk("alu_wb_pulse", {31'b0, wb_valid}, 32'd0);
      end else if (trap) begin
         chk("trap_no_req", {31'b0, mem_req}, 32'd0);
         chk("trap_bus_err", {31'b0, bus_err}, 32'd1);
         chk("trap_no_wb", {31'b0, wb_valid}, 32'd0);
         @(negedge clk);
         chk("trap_err_pulse", {31'b0, bus_err}, 32'd0);
         chk("trap_no_req2", {31'b0, mem_req}, 32'd0);
      end else begin
         chk("req", {31'b0, mem_req}, 32'd1);
         chk("we", {31'b0, mem_we}, {31'b0, !is_ld});
         chk("addr", mem_addr, a_exp);
         chk("be", {28'b0, mem_be}, exp_be(f3, alu));
         if (!is_ld) chk("wdata", mem_wdata, exp_wdata(f3, sd));
         if (ack) begin
            repeat (dly) begin
               @(negedge clk);
               chk("req_hold", {31'b0, mem_req}, 32'd1);
               chk("addr_hold", mem_addr, a_exp);
            end
            mem_ack = 1'b1; mem_rdata = rdata;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = ~rdata;
            chk("ack_wb_valid", {31'b0, wb_valid}, {31'b0, is_ld});
            if (is_ld) begin
               chk("ack_wb_rd", {27'b0, wb_rd}, {27'b0, rd});
               chk("ack_wb_data", wb_data, (rd == 0) ? 32'h0 : exp_load(f3, alu, rdata));
            end
            chk("ack_req_drop", {31'b0, mem_req}, 32'd0);
            chk("ack_no_err", {31'b0, bus_err}, 32'd0);
            chk("ack_ready", {31'b0, ex_ready}, 32'd1);
            @(negedge clk);
            chk("wb_pulse", {31'b0, wb_valid}, 32'd0);
         end else begin
            n = 0;
            while (mem_req && n < TO + 10) begin
               n++;
               @(negedge clk);
            end
            chk("timeout_req_cycles", n, TO);
            chk("timeout_bus_err", {31'b0, bus_err}, 32'd1);
            chk("timeout_no_wb", {31'b0, wb_valid}, 32'd0);
            chk("timeout_ready", {31'b0, ex_ready}, 32'd1);
            @(negedge clk);
            chk("timeout_err_pulse", {31'b0, bus_err}, 32'd0);
         end
      end
   endtask

   logic [4:0] other_ops [5] = '{5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b11011};
   logic [2:0] ld_f3 [5]     = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   initial begin
      logic [4:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_func3 = '0; ex_rd = '0;
      ex_alu_out = '0; ex_store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, ex_ready}, 32'd1);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases
      run_op(LD, 3'b010, 5'd3, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b1);     // lw
      run_op(LD, 3'b000, 5'd4, 32'h103, 32'h0, 1, 32'h80FF0000, 1'b1);     // lb
      run_op(LD, 3'b100, 5'd4, 32'h103, 32'h0, 1, 32'h80FF0000, 1'b1);     // lbu
      run_op(LD, 3'b001, 5'd6, 32'h102, 32'h0, 0, 32'h9234ABCD, 1'b1);     // lh upper
      run_op(ST, 3'b001, 5'd0, 32'h202, 32'h1234ABCD, 2, 32'h0, 1'b1);     // sh
      run_op(ST, 3'b000, 5'd0, 32'h201, 32'h000000A5, 0, 32'h0, 1'b1);     // sb
      run_op(5'b01100, 3'b000, 5'd7, 32'hCAFEF00D, 32'h0, 0, 32'h0, 1'b0); // alu op
      run_op(5'b01100, 3'b000, 5'd0, 32'hCAFEF00D, 32'h0, 0, 32'h0, 1'b0); // rd = 0
      run_op(BR, 3'b000, 5'd9, 32'h12345678, 32'h0, 0, 32'h0, 1'b0);       // branch
      run_op(LD, 3'b010, 5'd0, 32'h400, 32'h0, 2, 32'h55AA55AA, 1'b1);     // load to rd 0
      run_op(LD, 3'b010, 5'd8, 32'h500, 32'h0, 0, 32'h0, 1'b0);            // timeout
      run_op(LD, 3'b010, 5'd8, 32'h504, 32'h0, TO - 1, 32'h13579BDF, 1'b1); // ack on last wait cycle
      run_op(LD, 3'b010, 5'd5, 32'h101, 32'h0, 2, 32'h0BADF00D, 1'b1);     // misaligned lw

      // reset during an outstanding access, then a late ack
      ex_valid = 1'b1; ex_opcode = LD; ex_func3 = 3'b010; ex_rd = 5'd2; ex_alu_out = 32'h300;
      @(negedge clk);
      ex_valid = 1'b0;
      chk("rst_mid_req", {31'b0, mem_req}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req_drop", {31'b0, mem_req}, 32'd0);
      chk("rst_mid_addr", mem_addr, 32'h0);
      chk("rst_mid_be", {28'b0, mem_be}, 32'h0);
      chk("rst_mid_ready", {31'b0, ex_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("late_ack_wb", {31'b0, wb_valid}, 32'd0);
      chk("late_ack_req", {31'b0, mem_req}, 32'd0);
      chk("late_ack_err", {31'b0, bus_err}, 32'd0);
      chk("late_ack_data", wb_data, 32'h0);
      chk("late_ack_ready", {31'b0, ex_ready}, 32'd1);

      // randomized mix
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: begin op = LD; f3 = ld_f3[$urandom_range(0, 4)]; end
            1: begin op = ST; f3 = 3'($urandom_range(0, 2)); end
            2: begin op = BR; f3 = 3'($urandom); end
            default: begin op = other_ops[$urandom_range(0, 4)]; f3 = 3'($urandom); end
         endcase
         rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         run_op(op, f3, rd, $urandom, $urandom, $urandom_range(0, 6), $urandom, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
